// File: rtl/ll_manager_pkg.sv
// rtl/ll_manager_pkg.sv - shared defaults for the linked-list page manager
package ll_manager_pkg;

   localparam int DEF_SOURCES = 4;
   localparam int DEF_SINKS   = 4;
   localparam int DEF_LPSZ    = 8;
   localparam int NUM_PAGES   = 2 ** DEF_LPSZ;

endpackage

// File: rtl/ll_rr_arb.sv
// rtl/ll_rr_arb.sv - round-robin arbiter, priority restarts just after the last winner
module ll_rr_arb #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] req_i,
   input  logic             advance_i,
   output logic [WIDTH-1:0] gnt_o
);

   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] idx;
   logic          found;
   int            pos;

   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = 0; k < WIDTH; k++) begin
         pos = int'(ptr_q) + k;
         if (pos >= WIDTH) pos = pos - WIDTH;
         idx = PW'(pos);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            ptr_d      = (pos == WIDTH - 1) ? '0 : PW'(pos + 1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        ptr_q <= '0;
      else if (advance_i) ptr_q <= ptr_d;
   end

endmodule

// File: rtl/ll_manager.sv
// rtl/ll_manager.sv - free-page pool: fresh counter then returned-page FIFO, RR grant/return
// Define LL_MANAGER_CHECK_EN to add the allocated bitmap and the sticky err output.
module ll_manager
   import ll_manager_pkg::*;
#(
   parameter int SOURCES = DEF_SOURCES,
   parameter int SINKS   = DEF_SINKS,
   parameter int LPSZ    = DEF_LPSZ
) (
`ifdef LL_MANAGER_CHECK_EN
   output logic                  err,
`endif
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SOURCES-1:0]    pgreq,
   output logic [SOURCES-1:0]    pgack,
   output logic [SOURCES-1:0]    lprq_srdy,
   input  logic [SOURCES-1:0]    lprq_drdy,
   output logic [LPSZ-1:0]       lprq_page,
   input  logic [SINKS-1:0]      lprt_srdy,
   output logic [SINKS-1:0]      lprt_drdy,
   input  logic [SINKS*LPSZ-1:0] lprt_page_list
);

   localparam int              POOL_PAGES = 2 ** LPSZ;
   localparam logic [LPSZ:0]   POOL_FULL  = {1'b1, {LPSZ{1'b0}}};
   localparam logic [LPSZ:0]   ONE_CNT    = 1;
   localparam logic [LPSZ-1:0] ONE_PG     = 1;

   logic [LPSZ:0]        fresh_q, fresh_d;
   logic [LPSZ:0]        fifo_cnt_q, fifo_cnt_d;
   logic [LPSZ-1:0]      rd_q, rd_d, wr_q, wr_d;
   logic [LPSZ-1:0]      mem_q [POOL_PAGES];
   logic                 dv_q, dv_d;
   logic [SOURCES-1:0]   dsrc_q, dsrc_d, pgack_q, pgack_d;
   logic [LPSZ-1:0]      dpage_q, dpage_d;

   logic [SOURCES-1:0]   req_gnt;
   logic [SINKS-1:0]     rt_gnt;
   logic                 emptying, pool_ne, fresh_left, do_grant, pop, push, ret_any;
   logic [LPSZ-1:0]      alloc_page, ret_page;

`ifdef LL_MANAGER_CHECK_EN
   logic [POOL_PAGES-1:0] alloc_q, alloc_d;
   logic                  err_q, err_d;
`endif

   ll_rr_arb #(.WIDTH(SOURCES)) u_req_arb (
      .clk_i     (clk),
      .rst_ni    (reset),
      .req_i     (pgreq),
      .advance_i (do_grant),
      .gnt_o     (req_gnt)
   );

   ll_rr_arb #(.WIDTH(SINKS)) u_ret_arb (
      .clk_i     (clk),
      .rst_ni    (reset),
      .req_i     (lprt_srdy),
      .advance_i (ret_any),
      .gnt_o     (rt_gnt)
   );

   always_comb begin
      fresh_d    = fresh_q;
      fifo_cnt_d = fifo_cnt_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      dv_d       = dv_q;
      dsrc_d     = dsrc_q;
      dpage_d    = dpage_q;
      pgack_d    = '0;
      ret_page   = '0;

      fresh_left = (fresh_q != POOL_FULL);
      emptying   = dv_q && (|(dsrc_q & lprq_drdy));
      pool_ne    = fresh_left || (fifo_cnt_q != '0);
      do_grant   = (!dv_q || emptying) && pool_ne && (|pgreq);
      pop        = do_grant && !fresh_left;
      alloc_page = fresh_left ? fresh_q[LPSZ-1:0] : mem_q[rd_q];
      ret_any    = |lprt_srdy;

      for (int j = 0; j < SINKS; j++) begin
         if (rt_gnt[j]) ret_page = lprt_page_list[j*LPSZ +: LPSZ];
      end

`ifdef LL_MANAGER_CHECK_EN
      // Unallocated returns are still handshaken so the sink never stalls, but dropped.
      alloc_d = alloc_q;
      err_d   = err_q;
      push    = ret_any && alloc_q[ret_page] && (fifo_cnt_q != POOL_FULL);
      if (ret_any) begin
         if (alloc_q[ret_page]) alloc_d[ret_page] = 1'b0;
         else                   err_d             = 1'b1;
      end
      if (do_grant) alloc_d[alloc_page] = 1'b1;
`else
      push = ret_any && (fifo_cnt_q != POOL_FULL);
`endif

      if (emptying) dv_d = 1'b0;
      if (do_grant) begin
         dv_d    = 1'b1;
         dsrc_d  = req_gnt;
         dpage_d = alloc_page;
         pgack_d = req_gnt;
         if (fresh_left) fresh_d = fresh_q + ONE_CNT;
         else            rd_d    = rd_q + ONE_PG;
      end

      if (push) wr_d = wr_q + ONE_PG;
      fifo_cnt_d = fifo_cnt_q + {{LPSZ{1'b0}}, push} - {{LPSZ{1'b0}}, pop};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fresh_q    <= '0;
         fifo_cnt_q <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         dv_q       <= 1'b0;
         dsrc_q     <= '0;
         dpage_q    <= '0;
         pgack_q    <= '0;
      end else begin
         fresh_q    <= fresh_d;
         fifo_cnt_q <= fifo_cnt_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         dv_q       <= dv_d;
         dsrc_q     <= dsrc_d;
         dpage_q    <= dpage_d;
         pgack_q    <= pgack_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= ret_page;
   end

`ifdef LL_MANAGER_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alloc_q <= '0;
         err_q   <= 1'b0;
      end else begin
         alloc_q <= alloc_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;
`endif

   assign pgack     = pgack_q;
   assign lprq_srdy = dv_q ? dsrc_q : '0;
   assign lprq_page = dpage_q;
   assign lprt_drdy = reset ? rt_gnt : '0;

endmodule

// File: tb/tb_ll_manager.sv
// tb/tb_ll_manager.sv - directed vector bench for ll_manager (CHECK_EN test under LL_MANAGER_CHECK_EN)
module tb_ll_manager;

   logic        clk;
   logic        reset;
   logic [3:0]  pgreq;
   logic [3:0]  pgack;
   logic [3:0]  lprq_srdy;
   logic [3:0]  lprq_drdy;
   logic [7:0]  lprq_page;
   logic [3:0]  lprt_srdy;
   logic [3:0]  lprt_drdy;
   logic [31:0] lprt_page_list;
`ifdef LL_MANAGER_CHECK_EN
   logic        err;
`endif

   int checks   = 0;
   int failures = 0;

   ll_manager dut (
`ifdef LL_MANAGER_CHECK_EN
      .err            (err),
`endif
      .clk            (clk),
      .reset          (reset),
      .pgreq          (pgreq),
      .pgack          (pgack),
      .lprq_srdy      (lprq_srdy),
      .lprq_drdy      (lprq_drdy),
      .lprq_page      (lprq_page),
      .lprt_srdy      (lprt_srdy),
      .lprt_drdy      (lprt_drdy),
      .lprt_page_list (lprt_page_list)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] pgreq;
      logic [3:0] drdy;
      logic [3:0] rsrdy;
      logic [3:0] e_ack;
      logic [3:0] e_srdy;
      logic [7:0] e_page;
      logic [3:0] e_rdrdy;
   } vec_t;

   vec_t tv [64];
   int   nv = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      pgreq          = '0;
      lprq_drdy      = '0;
      lprt_srdy      = '0;
      lprt_page_list = '0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic add(input logic [3:0] pr, input logic [3:0] dr, input logic [3:0] rs,
                      input logic [3:0] ea, input logic [3:0] es, input logic [7:0] ep,
                      input logic [3:0] erd);
      tv[nv] = '{pgreq: pr, drdy: dr, rsrdy: rs, e_ack: ea, e_srdy: es, e_page: ep, e_rdrdy: erd};
      nv++;
   endtask

   initial begin
      int n;
      int acks;
      int seen;

      // Reset state with every input asserted
      reset          = 1'b0;
      pgreq          = 4'b1111;
      lprq_drdy      = 4'b1111;
      lprt_srdy      = 4'b1111;
      lprt_page_list = 32'h0302_0100;
      tick();
      chk("rst_pgack", pgack, 0);
      chk("rst_srdy", lprq_srdy, 0);
      chk("rst_page", lprq_page, 0);
      chk("rst_lprt_drdy", lprt_drdy, 0);

      // Four-way round robin, stall window, return arbitration
      add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);
      add(4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 8'h00, 4'b0000);
      add(4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 8'h01, 4'b0000);
      add(4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 8'h02, 4'b0000);
      add(4'b1111, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 8'h03, 4'b0000);
      add(4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 8'h04, 4'b0000);
      add(4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 8'h05, 4'b0000);
      for (int i = 0; i < 9; i++)
         add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'h05, 4'b0000);
      add(4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 8'h05, 4'b0001);
      add(4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 8'h05, 4'b0010);
      add(4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 8'h05, 4'b0100);
      add(4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 8'h05, 4'b1000);
      add(4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 8'h05, 4'b0001);
      add(4'b1111, 4'b0000, 4'b1010, 4'b0000, 4'b0010, 8'h05, 4'b0010);
      add(4'b1111, 4'b0000, 4'b1010, 4'b0000, 4'b0010, 8'h05, 4'b1000);
      add(4'b1111, 4'b0000, 4'b1010, 4'b0000, 4'b0010, 8'h05, 4'b0010);
      add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'h05, 4'b0000);
      add(4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 8'h05, 4'b0100);
      add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 8'h05, 4'b0000);
      add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000);

      do_reset();
      for (int i = 0; i < nv; i++) begin
         pgreq     = tv[i].pgreq;
         lprq_drdy = tv[i].drdy;
         lprt_srdy = tv[i].rsrdy;
         #1;
         chk($sformatf("vec%0d_pgack", i), pgack, tv[i].e_ack);
         chk($sformatf("vec%0d_srdy", i), lprq_srdy, tv[i].e_srdy);
         if (tv[i].e_srdy != 4'b0000)
            chk($sformatf("vec%0d_page", i), lprq_page, tv[i].e_page);
         chk($sformatf("vec%0d_lprt_drdy", i), lprt_drdy, tv[i].e_rdrdy);
         tick();
      end

      // Reset during an in-flight delivery restores the full pool
      pgreq     = 4'b0010;
      lprq_drdy = 4'b0000;
      tick();
      pgreq = 4'b0000;
      chk("midrst_pre_srdy", lprq_srdy, 4'b0010);
      chk("midrst_pre_page", lprq_page, 8'h06);
      reset     = 1'b0;
      lprt_srdy = 4'b1111;
      #1;
      chk("midrst_srdy", lprq_srdy, 0);
      chk("midrst_page", lprq_page, 0);
      chk("midrst_lprt_drdy", lprt_drdy, 0);
      tick();
      lprt_srdy = 4'b0000;
      reset     = 1'b1;
      pgreq     = 4'b0001;
      lprq_drdy = 4'b0001;
      tick();
      chk("midrst_post_ack", pgack, 4'b0001);
      chk("midrst_post_page", lprq_page, 8'h00);

      // Single source streaming pages 0..3
      do_reset();
      pgreq     = 4'b0001;
      lprq_drdy = 4'b0001;
      #1;
      chk("seq1_idle_srdy", lprq_srdy, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("seq1_ack%0d", k), pgack, 4'b0001);
         chk($sformatf("seq1_srdy%0d", k), lprq_srdy, 4'b0001);
         chk($sformatf("seq1_page%0d", k), lprq_page, k);
         tick();
      end

      // Exhaust the pool, then one return from sink 2
      do_reset();
      pgreq     = 4'b0001;
      lprq_drdy = 4'b0001;
      n    = 0;
      acks = 0;
      for (int c = 0; c < 400 && n < 256; c++) begin
         if (pgack[0]) acks++;
         if (lprq_srdy[0]) begin
            chk($sformatf("exh_page%0d", n), lprq_page, n);
            n++;
         end
         tick();
      end
      chk("exh_count", n, 256);
      chk("exh_acks", acks, 256);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if ((pgack != 0) || (lprq_srdy != 0)) seen++;
         tick();
      end
      chk("empty_no_grant", seen, 0);
      lprt_page_list = 32'h002A_0000;
      lprt_srdy      = 4'b0100;
      #1;
      chk("ret_drdy", lprt_drdy, 4'b0100);
      tick();
      lprt_srdy = 4'b0000;
      chk("ret_no_early_ack", pgack, 0);
      tick();
      chk("ret_ack", pgack, 4'b0001);
      chk("ret_srdy", lprq_srdy, 4'b0001);
      chk("ret_page", lprq_page, 8'h2A);
      tick();
      tick();
      chk("ret_drained_srdy", lprq_srdy, 0);

`ifdef LL_MANAGER_CHECK_EN
      // Returning a page that was never allocated is flagged and dropped
      do_reset();
      chk("chk_err_reset", err, 0);
      lprt_page_list = 32'h0080_0000;
      lprt_srdy      = 4'b0100;
      #1;
      chk("chk_bad_drdy", lprt_drdy, 4'b0100);
      tick();
      lprt_srdy = 4'b0000;
      chk("chk_err_set", err, 1);
      pgreq     = 4'b0001;
      lprq_drdy = 4'b0001;
      n    = 0;
      seen = 0;
      for (int c = 0; c < 300; c++) begin
         if (lprq_srdy[0]) begin
            n++;
            if (lprq_page == 8'h80) seen++;
         end
         tick();
      end
      chk("chk_total", n, 256);
      chk("chk_page80_once", seen, 1);
      chk("chk_err_sticky", err, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
